// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - ID-stage hazard controller and FP multi-cycle unit sequencer
// Stalls/bubbles ID on load-use, in-flight FP RAW/WAW, unit-busy and reserved WB-slot hazards.
module hazard_stall_controller #(
   parameter int DIV_LAT = 16,
   parameter int WB_DIST = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic [4:0] id_rs3,
   input  logic [2:0] id_src_used,
   input  logic [2:0] id_src_fp,
   input  logic [4:0] id_rd,
   input  logic       id_rd_fp,
   input  logic       id_reg_write,
   input  logic       id_is_mcyc,
   input  logic       id_ex_mem_read,
   input  logic [4:0] id_ex_rd,
   input  logic       id_ex_rd_fp,
   input  logic       ex_flush,
   output logic       stall_id,
   output logic       bubble_ex,
   output logic [2:0] stall_cause,
   output logic       mcyc_start,
   output logic       mcyc_busy,
   output logic       mcyc_wb_valid,
   output logic [4:0] mcyc_wb_rd
);

   typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

   localparam logic [4:0] LAT_M1 = 5'(DIV_LAT - 1);
   localparam logic [4:0] WB_CNT = 5'(WB_DIST - 1);

   state_t     state, state_n;
   logic [4:0] cnt, cnt_n;
   logic [4:0] pend_rd;

   logic load_use, raw_waw, struct_hz, wb_slot, go;

   // x0 never creates a dependency; f0 is an ordinary register.
   function automatic logic src_match(input logic used, input logic fp, input logic [4:0] idx,
                                      input logic [4:0] r, input logic f);
      return used & (fp == f) & (idx == r) & (f | (r != 5'd0));
   endfunction

   function automatic logic any_match(input logic [4:0] r, input logic f);
      return src_match(id_src_used[0], id_src_fp[0], id_rs1, r, f) |
             src_match(id_src_used[1], id_src_fp[1], id_rs2, r, f) |
             src_match(id_src_used[2], id_src_fp[2], id_rs3, r, f);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= 5'd0;
         pend_rd <= 5'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (mcyc_start) pend_rd <= id_rd;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: if (mcyc_start) begin
            state_n = BUSY;
            cnt_n   = LAT_M1;
         end
         BUSY: if (cnt == 5'd0) state_n = WB;
               else             cnt_n   = cnt - 5'd1;
         WB:      state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      load_use  = id_ex_mem_read & any_match(id_ex_rd, id_ex_rd_fp);
      raw_waw   = (state != IDLE) &
                  (any_match(pend_rd, 1'b1) | (id_reg_write & id_rd_fp & (id_rd == pend_rd)));
      struct_hz = id_is_mcyc & (state != IDLE);
      // Keep the ID instruction out of the FP WB port in the cycle the unit owns it.
      wb_slot   = (state == BUSY) & (cnt == WB_CNT);
      go        = id_valid & !ex_flush;

      stall_id      = go & (load_use | raw_waw | struct_hz | wb_slot);
      bubble_ex     = stall_id;
      stall_cause   = go ? {struct_hz | wb_slot, raw_waw, load_use} : 3'b000;
      mcyc_start    = id_valid & id_is_mcyc & (state == IDLE) & !stall_id & !ex_flush;
      mcyc_busy     = (state != IDLE);
      mcyc_wb_valid = (state == WB);
      mcyc_wb_rd    = pend_rd;
   end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed + randomized bench for hazard_stall_controller
// Reference model tracks cycles remaining until the FP unit is idle again.
module tb_hazard_stall_controller;

   localparam int DIV_LAT = 16;
   localparam int WB_DIST = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       id_valid, id_rd_fp, id_reg_write, id_is_mcyc, id_ex_mem_read, id_ex_rd_fp, ex_flush;
   logic [4:0] id_rs1, id_rs2, id_rs3, id_rd, id_ex_rd;
   logic [2:0] id_src_used, id_src_fp;
   logic       stall_id, bubble_ex, mcyc_start, mcyc_busy, mcyc_wb_valid;
   logic [2:0] stall_cause;
   logic [4:0] mcyc_wb_rd;

   int tests = 0;
   int fails = 0;
   int rem = 0;
   logic [4:0] mrd = 5'd0;

   logic       o_stall, o_start, o_busy, o_wbv;
   logic [2:0] o_cause;
   logic [4:0] o_rd;
   int         cnt_a;

   hazard_stall_controller #(.DIV_LAT(DIV_LAT), .WB_DIST(WB_DIST)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
      .id_src_used(id_src_used), .id_src_fp(id_src_fp),
      .id_rd(id_rd), .id_rd_fp(id_rd_fp), .id_reg_write(id_reg_write),
      .id_is_mcyc(id_is_mcyc), .id_ex_mem_read(id_ex_mem_read),
      .id_ex_rd(id_ex_rd), .id_ex_rd_fp(id_ex_rd_fp), .ex_flush(ex_flush),
      .stall_id(stall_id), .bubble_ex(bubble_ex), .stall_cause(stall_cause),
      .mcyc_start(mcyc_start), .mcyc_busy(mcyc_busy),
      .mcyc_wb_valid(mcyc_wb_valid), .mcyc_wb_rd(mcyc_wb_rd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m(input int i, input logic [4:0] r, input bit f);
      logic [4:0] idx;
      idx = (i == 0) ? id_rs1 : (i == 1) ? id_rs2 : id_rs3;
      return id_src_used[i] && (id_src_fp[i] == f) && (idx == r) && (f || r != 5'd0);
   endfunction

   function automatic bit any_m(input logic [4:0] r, input bit f);
      return m(0, r, f) || m(1, r, f) || m(2, r, f);
   endfunction

   task automatic step(input string tag);
      bit lu, raw, st, wbs, go, e_stall, e_start;
      logic [2:0] e_cause;
      #1;
      lu  = id_ex_mem_read && any_m(id_ex_rd, id_ex_rd_fp);
      raw = (rem > 0) && (any_m(mrd, 1'b1) || (id_reg_write && id_rd_fp && id_rd == mrd));
      st  = id_is_mcyc && (rem > 0);
      wbs = (rem == WB_DIST + 1);
      go  = id_valid && !ex_flush;
      e_stall = go && (lu || raw || st || wbs);
      e_cause = go ? {st || wbs, raw, lu} : 3'b000;
      e_start = id_valid && id_is_mcyc && (rem == 0) && !e_stall && !ex_flush;
      chk({tag, ".stall"}, 32'(stall_id), 32'(e_stall));
      chk({tag, ".bubble"}, 32'(bubble_ex), 32'(e_stall));
      chk({tag, ".cause"}, 32'(stall_cause), 32'(e_cause));
      chk({tag, ".start"}, 32'(mcyc_start), 32'(e_start));
      chk({tag, ".busy"}, 32'(mcyc_busy), 32'(rem > 0));
      chk({tag, ".wbv"}, 32'(mcyc_wb_valid), 32'(rem == 1));
      chk({tag, ".wbrd"}, 32'(mcyc_wb_rd), 32'(mrd));
      o_stall = stall_id; o_cause = stall_cause; o_start = mcyc_start;
      o_busy = mcyc_busy; o_wbv = mcyc_wb_valid; o_rd = mcyc_wb_rd;
      @(posedge clk);
      if (!rst_n) begin
         rem = 0; mrd = 5'd0;
      end else if (e_start) begin
         rem = DIV_LAT + 1; mrd = id_rd;
      end else if (rem > 0) begin
         rem--;
      end
      @(negedge clk);
   endtask

   task automatic clear_all();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs3 = 0; id_src_used = 0; id_src_fp = 0;
      id_rd = 0; id_rd_fp = 0; id_reg_write = 0; id_is_mcyc = 0;
      id_ex_mem_read = 0; id_ex_rd = 0; id_ex_rd_fp = 0; ex_flush = 0;
   endtask

   task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] used,
                        input logic [2:0] fp, input logic [4:0] rd, input logic rd_fp,
                        input logic wr, input logic mc);
      id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rs3 = 0; id_src_used = used; id_src_fp = fp;
      id_rd = rd; id_rd_fp = rd_fp; id_reg_write = wr; id_is_mcyc = mc;
   endtask

   initial begin
      clear_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      step("reset");
      chk("reset.busy0", 32'(o_busy), 0);
      rst_n = 1;

      // load-use on x5, then x0 destination
      instr(5, 7, 3'b011, 3'b000, 6, 0, 1, 0);
      id_ex_mem_read = 1; id_ex_rd = 5;
      step("t1a");
      chk("t1.cause", 32'(o_cause), 32'(3'b001));
      id_ex_mem_read = 0;
      step("t1b");
      chk("t1.release", 32'(o_stall), 0);
      id_ex_mem_read = 1; id_ex_rd = 0; id_rs1 = 0;
      step("t1c");
      chk("t1.x0", 32'(o_stall), 0);
      id_ex_mem_read = 0;

      // fdiv.s f3 then dependent fadd.s f4,f3,f1
      instr(1, 2, 3'b011, 3'b011, 3, 1, 1, 1);
      step("t2");
      chk("t2.start", 32'(o_start), 1);
      instr(3, 1, 3'b011, 3'b011, 4, 1, 1, 0);
      cnt_a = 0;
      for (int k = 0; k < DIV_LAT + 1; k++) begin
         step("t3");
         chk("t3.stall", 32'(o_stall), 1);
         chk("t3.raw", 32'(o_cause[1]), 1);
         if (o_wbv) begin
            cnt_a++;
            chk("t2.wbrd", 32'(o_rd), 3);
            chk("t2.wbcyc", k, DIV_LAT);
         end
      end
      chk("t2.wbcount", cnt_a, 1);
      step("t3i");
      chk("t3.issue", 32'(o_stall), 0);
      chk("t3.idle", 32'(o_busy), 0);

      // back-to-back fdiv, then unrelated integer add
      instr(10, 11, 3'b011, 3'b011, 5, 1, 0, 1);
      step("t4a");
      chk("t4.start1", 32'(o_start), 1);
      instr(12, 13, 3'b011, 3'b011, 6, 1, 0, 1);
      for (int k = 0; k < DIV_LAT + 1; k++) begin
         step("t4b");
         chk("t4.struct", 32'(o_cause), 32'(3'b100));
      end
      step("t4c");
      chk("t4.start2", 32'(o_start), 1);
      instr(2, 3, 3'b011, 3'b000, 1, 0, 1, 0);
      cnt_a = 0;
      for (int k = 0; k < DIV_LAT + 1; k++) begin
         step("t4d");
         chk("t4.slot", 32'(o_stall), 32'(k == DIV_LAT + 1 - (WB_DIST + 1)));
         if (o_stall) cnt_a++;
      end
      chk("t4.slotcount", cnt_a, 1);

      // ex_flush dominates; in-flight op survives a flush
      instr(1, 2, 3'b011, 3'b011, 7, 1, 0, 1);
      ex_flush = 1;
      step("t5a");
      chk("t5.nostart", 32'(o_start), 0);
      chk("t5.nostall", 32'(o_stall), 0);
      ex_flush = 0;
      step("t5b");
      chk("t5.start", 32'(o_start), 1);
      instr(7, 7, 3'b011, 3'b011, 7, 1, 1, 0);
      ex_flush = 1;
      cnt_a = 0;
      for (int k = 0; k < DIV_LAT + 1; k++) begin
         step("t5c");
         if (o_wbv) cnt_a++;
      end
      chk("t5.wb", cnt_a, 1);
      ex_flush = 0;

      // reset mid-op at cnt==7
      instr(14, 15, 3'b011, 3'b011, 9, 1, 0, 1);
      step("t6a");
      chk("t6.start", 32'(o_start), 1);
      id_valid = 0; id_is_mcyc = 0;
      for (int k = 0; k < DIV_LAT - 1 - 7; k++) step("t6b");
      rst_n = 0;
      step("t6r");
      rst_n = 1;
      instr(9, 1, 3'b011, 3'b011, 10, 1, 1, 0);
      cnt_a = 0;
      for (int k = 0; k < 4; k++) begin
         step("t6c");
         if (o_stall || o_wbv || o_busy) cnt_a++;
      end
      chk("t6.abandoned", cnt_a, 0);

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         id_valid       = ($urandom_range(0, 9) != 0);
         id_rs1         = 5'($urandom_range(0, 3));
         id_rs2         = 5'($urandom_range(0, 3));
         id_rs3         = 5'($urandom_range(0, 3));
         id_src_used    = 3'($urandom);
         id_src_fp      = 3'($urandom);
         id_rd          = 5'($urandom_range(0, 3));
         id_rd_fp       = 1'($urandom);
         id_reg_write   = 1'($urandom);
         id_is_mcyc     = ($urandom_range(0, 5) == 0);
         id_ex_mem_read = 1'($urandom);
         id_ex_rd       = 5'($urandom_range(0, 3));
         id_ex_rd_fp    = 1'($urandom);
         ex_flush       = ($urandom_range(0, 7) == 0);
         rst_n          = ($urandom_range(0, 99) != 0);
         step("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
